// File: rtl/branch_resolver_if.sv
// Bus between fetch/execute and the branch resolver: push port from fetch,
// resolve port from execute, and the flush/redirect and PHT update outputs.
interface branch_resolver_if #(
    parameter int DEPTH_LOG2 = 2
);
    logic                  push_valid;
    logic [31:0]           push_pc;
    logic                  push_pred;
    logic                  push_ready;
    logic                  resolve_valid;
    logic                  resolve_taken;
    logic [31:0]           resolve_target;
    logic                  resolve_ready;
    logic                  flush;
    logic [31:0]           redirect_pc;
    logic [31:0]           pc_update;
    logic                  update;
    logic                  taken;
    logic [DEPTH_LOG2:0]   occupancy;
    logic [31:0]           mispredict_count;

    modport master (
        output push_valid, push_pc, push_pred,
        output resolve_valid, resolve_taken, resolve_target,
        input  push_ready, resolve_ready, flush, redirect_pc,
        input  pc_update, update, taken, occupancy, mispredict_count
    );

    modport slave (
        input  push_valid, push_pc, push_pred,
        input  resolve_valid, resolve_taken, resolve_target,
        output push_ready, resolve_ready, flush, redirect_pc,
        output pc_update, update, taken, occupancy, mispredict_count
    );
endinterface

// File: rtl/branch_resolver.sv
// Branch resolver: in-order queue of predicted conditional branches, resolved
// oldest-first. Mispredicts produce a one-cycle flush with the correct fetch
// PC and wipe the (wrong-path) queue. Every resolution is fed to the PHT
// through a 2-entry buffer and a registered stage that never strobes
// `update` on two consecutive cycles.
module branch_resolver #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rstn,
    branch_resolver_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Branch queue storage and control
    logic [31:0]           q_pc   [DEPTH];
    logic                  q_pred [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;

    // Update buffer storage and control
    logic [31:0]           ub_pc    [2];
    logic                  ub_taken [2];
    logic                  ub_rd;
    logic                  ub_wr;
    logic [1:0]            ub_cnt;

    // Registered outputs
    logic                  flush_q;
    logic [31:0]           redirect_q;
    logic [31:0]           mcount_q;
    logic                  update_q;
    logic [31:0]           pc_update_q;
    logic                  taken_q;

    // Handshakes and derived control
    logic                  push_fire;
    logic                  res_fire;
    logic [31:0]           head_pc;
    logic                  head_pred;
    logic                  mispred;
    logic                  cand_valid;
    logic [31:0]           cand_pc;
    logic                  cand_taken;
    logic                  issue;
    logic                  ub_pop;
    logic                  ub_push;

    // Count can never exceed DEPTH, so its MSB alone means "full".
    assign bus.push_ready    = ~count[DEPTH_LOG2];
    assign bus.resolve_ready = (count != '0) && (ub_cnt != 2'd2);
    assign bus.occupancy     = count;
    assign bus.flush         = flush_q;
    assign bus.redirect_pc   = redirect_q;
    assign bus.mispredict_count = mcount_q;
    assign bus.update        = update_q;
    assign bus.pc_update     = pc_update_q;
    assign bus.taken         = taken_q;

    assign push_fire = bus.push_valid && bus.push_ready;
    assign res_fire  = bus.resolve_valid && bus.resolve_ready;
    assign head_pc   = q_pc[rd_ptr];
    assign head_pred = q_pred[rd_ptr];
    assign mispred   = res_fire && (bus.resolve_taken != head_pred);

    // Pick the next update candidate: buffered entries first to keep resolve
    // order, otherwise bypass this cycle's resolution straight to the stage.
    always_comb begin
        cand_valid = 1'b0;
        cand_pc    = head_pc;
        cand_taken = bus.resolve_taken;
        if (ub_cnt != 2'd0) begin
            cand_valid = 1'b1;
            cand_pc    = ub_pc[ub_rd];
            cand_taken = ub_taken[ub_rd];
        end else if (res_fire) begin
            cand_valid = 1'b1;
        end
        issue   = !update_q && cand_valid;
        ub_pop  = issue && (ub_cnt != 2'd0);
        ub_push = res_fire && !(issue && (ub_cnt == 2'd0));
    end

    // Queue pointers and count; a mispredict empties the queue outright,
    // including any push accepted in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (mispred) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + 1'b1;
            if (res_fire)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_fire, res_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Queue payload; stale slots are harmless because pointers gate reads.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            q_pc[wr_ptr]   <= bus.push_pc;
            q_pred[wr_ptr] <= bus.push_pred;
        end
    end

    // Mispredict flush pulse, redirect PC and running mispredict count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            flush_q    <= 1'b0;
            redirect_q <= '0;
            mcount_q   <= '0;
        end else begin
            flush_q <= mispred;
            if (mispred) begin
                redirect_q <= bus.resolve_taken ? bus.resolve_target
                                                : head_pc + 32'd4;
                mcount_q   <= mcount_q + 32'd1;
            end
        end
    end

    // Update buffer pointers and fill level; flushes leave it untouched.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ub_rd  <= 1'b0;
            ub_wr  <= 1'b0;
            ub_cnt <= 2'd0;
        end else begin
            if (ub_push) ub_wr <= ~ub_wr;
            if (ub_pop)  ub_rd <= ~ub_rd;
            case ({ub_push, ub_pop})
                2'b10:   ub_cnt <= ub_cnt + 2'd1;
                2'b01:   ub_cnt <= ub_cnt - 2'd1;
                default: ub_cnt <= ub_cnt;
            endcase
        end
    end

    // Update buffer payload: the resolved branch's PC and actual direction.
    always_ff @(posedge clk) begin
        if (ub_push) begin
            ub_pc[ub_wr]    <= head_pc;
            ub_taken[ub_wr] <= bus.resolve_taken;
        end
    end

    // Paced update stage: load only when idle last cycle, so strobes are
    // always separated by at least one low cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            update_q    <= 1'b0;
            pc_update_q <= '0;
            taken_q     <= 1'b0;
        end else begin
            update_q <= issue;
            if (issue) begin
                pc_update_q <= cand_pc;
                taken_q     <= cand_taken;
            end
        end
    end
endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: a vector table for the single-cycle
// behaviour plus hand-written sequences for pacing, buffer back-pressure and
// asynchronous reset in mid-operation.
module tb_branch_resolver;
    logic clk = 1'b0;
    logic rstn = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    branch_resolver_if #(.DEPTH_LOG2(2)) bus ();

    branch_resolver #(.DEPTH_LOG2(2)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [31:0] ppc;
        logic        pp;
        logic        rv;
        logic        rt;
        logic [31:0] rtg;
        logic        e_flush;
        logic [31:0] e_redir;
        logic        e_upd;
        logic [31:0] e_pcu;
        logic        e_tk;
        logic [31:0] e_occ;
        logic        e_pr;
        logic        e_rr;
        logic [31:0] e_mc;
    } vec_t;

    vec_t vec [64];
    int   nvec = 0;

    task automatic add(input logic pv, input logic [31:0] ppc, input logic pp,
                       input logic rv, input logic rt, input logic [31:0] rtg,
                       input logic ef, input logic [31:0] er, input logic eu,
                       input logic [31:0] epc, input logic etk,
                       input logic [31:0] eocc, input logic epr, input logic err,
                       input logic [31:0] emc);
        vec[nvec] = '{pv, ppc, pp, rv, rt, rtg, ef, er, eu, epc, etk, eocc, epr, err, emc};
        nvec++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs and sample just after the rising edge.
    task automatic step(input logic pv, input logic [31:0] ppc, input logic pp,
                        input logic rv, input logic rt, input logic [31:0] rtg);
        @(negedge clk);
        bus.push_valid     = pv;
        bus.push_pc        = ppc;
        bus.push_pred      = pp;
        bus.resolve_valid  = rv;
        bus.resolve_taken  = rt;
        bus.resolve_target = rtg;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string tag, input logic ef, input logic [31:0] er,
                              input logic eu, input logic [31:0] epc, input logic etk,
                              input logic [31:0] eocc, input logic epr, input logic err,
                              input logic [31:0] emc);
        chk({tag, " flush"}, 32'(bus.flush), 32'(ef));
        if (ef) chk({tag, " redirect_pc"}, bus.redirect_pc, er);
        chk({tag, " update"}, 32'(bus.update), 32'(eu));
        if (eu) begin
            chk({tag, " pc_update"}, bus.pc_update, epc);
            chk({tag, " taken"}, 32'(bus.taken), 32'(etk));
        end
        chk({tag, " occupancy"}, 32'(bus.occupancy), eocc);
        chk({tag, " push_ready"}, 32'(bus.push_ready), 32'(epr));
        chk({tag, " resolve_ready"}, 32'(bus.resolve_ready), 32'(err));
        chk({tag, " mispredict_count"}, bus.mispredict_count, emc);
    endtask

    task automatic expect_reset(input string tag);
        chk({tag, " flush"}, 32'(bus.flush), 32'd0);
        chk({tag, " update"}, 32'(bus.update), 32'd0);
        chk({tag, " taken"}, 32'(bus.taken), 32'd0);
        chk({tag, " redirect_pc"}, bus.redirect_pc, 32'd0);
        chk({tag, " pc_update"}, bus.pc_update, 32'd0);
        chk({tag, " occupancy"}, 32'(bus.occupancy), 32'd0);
        chk({tag, " mispredict_count"}, bus.mispredict_count, 32'd0);
        chk({tag, " push_ready"}, 32'(bus.push_ready), 32'd1);
        chk({tag, " resolve_ready"}, 32'(bus.resolve_ready), 32'd0);
    endtask

    initial begin
        logic [31:0] pc_j;
        logic        pr_j;

        bus.push_valid     = 1'b0;
        bus.push_pc        = '0;
        bus.push_pred      = 1'b0;
        bus.resolve_valid  = 1'b0;
        bus.resolve_taken  = 1'b0;
        bus.resolve_target = '0;

        // Vector table: pv ppc pp rv rt rtg | flush redir upd pcu tk occ pr rr mc
        // Simple correct resolve, then not-taken mispredict.
        add(1, 32'h100, 1, 0, 0, 0,        0, 0, 0, 0, 0,          1, 1, 1, 0);
        add(0, 0, 0, 1, 1, 0,              0, 0, 1, 32'h100, 1,    0, 1, 0, 0);
        add(1, 32'h200, 1, 0, 0, 0,        0, 0, 0, 0, 0,          1, 1, 1, 0);
        add(0, 0, 0, 1, 0, 32'h300,        1, 32'h204, 1, 32'h200, 0, 0, 1, 0, 1);
        // Fill the queue, then a push while full is dropped.
        add(1, 32'h1000, 0, 0, 0, 0,       0, 0, 0, 0, 0,          1, 1, 1, 1);
        add(1, 32'h1004, 0, 0, 0, 0,       0, 0, 0, 0, 0,          2, 1, 1, 1);
        add(1, 32'h1008, 0, 0, 0, 0,       0, 0, 0, 0, 0,          3, 1, 1, 1);
        add(1, 32'h100C, 0, 0, 0, 0,       0, 0, 0, 0, 0,          4, 0, 1, 1);
        add(1, 32'h2000, 0, 0, 0, 0,       0, 0, 0, 0, 0,          4, 0, 1, 1);
        // Taken mispredict with push_valid high clears the queue.
        add(1, 32'h3000, 0, 1, 1, 32'h4000, 1, 32'h4000, 1, 32'h1000, 1, 0, 1, 0, 2);
        // Accepted push in the mispredict cycle is discarded.
        add(1, 32'h500, 1, 0, 0, 0,        0, 0, 0, 0, 0,          1, 1, 1, 2);
        add(1, 32'h600, 0, 1, 0, 32'h900,  1, 32'h504, 1, 32'h500, 0, 0, 1, 0, 3);
        // Resolve while empty is ignored.
        add(0, 0, 0, 1, 1, 32'h700,        0, 0, 0, 0, 0,          0, 1, 0, 3);
        // Two entries, then push+resolve pairs across several pointer wraps.
        add(1, 32'hA00, 1, 0, 0, 0,        0, 0, 0, 0, 0,          1, 1, 1, 3);
        add(1, 32'hA04, 0, 0, 0, 0,        0, 0, 0, 0, 0,          2, 1, 1, 3);
        for (int j = 0; j < 8; j++) begin
            pc_j = 32'hA00 + 32'(4 * j);
            pr_j = (j % 2 == 0);
            add(1, pc_j + 32'd8, pr_j, 1, pr_j, 0, 0, 0, 1, pc_j, pr_j, 2, 1, 1, 3);
            add(0, 0, 0, 0, 0, 0,              0, 0, 0, 0, 0,        2, 1, 1, 3);
        end

        // Reset state
        #2 rstn = 1'b0;
        #1 expect_reset("reset");
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < nvec; i++) begin
            step(vec[i].pv, vec[i].ppc, vec[i].pp, vec[i].rv, vec[i].rt, vec[i].rtg);
            expect_all($sformatf("vec%0d", i), vec[i].e_flush, vec[i].e_redir,
                       vec[i].e_upd, vec[i].e_pcu, vec[i].e_tk, vec[i].e_occ,
                       vec[i].e_pr, vec[i].e_rr, vec[i].e_mc);
        end

        // Pacing: queue holds A20(1), A24(0); add A28(1), A2C(0).
        step(1, 32'hA28, 1, 0, 0, 0); expect_all("pace_s1", 0, 0, 0, 0, 0, 3, 1, 1, 3);
        step(1, 32'hA2C, 0, 0, 0, 0); expect_all("pace_s2", 0, 0, 0, 0, 0, 4, 0, 1, 3);
        step(0, 0, 0, 1, 1, 0);       expect_all("pace_t0", 0, 0, 1, 32'hA20, 1, 3, 1, 1, 3);
        step(1, 32'hA30, 1, 1, 0, 0); expect_all("pace_t1", 0, 0, 0, 0, 0, 3, 1, 1, 3);
        step(0, 0, 0, 1, 1, 0);       expect_all("pace_t2", 0, 0, 1, 32'hA24, 0, 2, 1, 1, 3);
        step(0, 0, 0, 1, 0, 0);       expect_all("pace_t3", 0, 0, 0, 0, 0, 1, 1, 0, 3);
        // Resolve while the update buffer is full is ignored (it would mispredict).
        step(0, 0, 0, 1, 0, 32'hBAD); expect_all("pace_t4", 0, 0, 1, 32'hA28, 1, 1, 1, 1, 3);
        step(0, 0, 0, 0, 0, 0);       expect_all("pace_t5", 0, 0, 0, 0, 0, 1, 1, 1, 3);
        step(0, 0, 0, 0, 0, 0);       expect_all("pace_t6", 0, 0, 1, 32'hA2C, 0, 1, 1, 1, 3);
        step(0, 0, 0, 0, 0, 0);       expect_all("pace_t7", 0, 0, 0, 0, 0, 1, 1, 1, 3);
        step(0, 0, 0, 0, 0, 0);       expect_all("pace_t8", 0, 0, 0, 0, 0, 1, 1, 1, 3);

        // Build 3 queued entries with an update still buffered.
        step(1, 32'hA34, 0, 0, 0, 0); expect_all("mid_m1", 0, 0, 0, 0, 0, 2, 1, 1, 3);
        step(1, 32'hA38, 1, 0, 0, 0); expect_all("mid_m2", 0, 0, 0, 0, 0, 3, 1, 1, 3);
        step(1, 32'hA3C, 0, 1, 1, 0); expect_all("mid_m3", 0, 0, 1, 32'hA30, 1, 3, 1, 1, 3);
        step(1, 32'hA40, 1, 1, 0, 0); expect_all("mid_m4", 0, 0, 0, 0, 0, 3, 1, 1, 3);

        // Asynchronous reset between edges.
        bus.push_valid    = 1'b0;
        bus.resolve_valid = 1'b0;
        #2 rstn = 1'b0;
        #1 expect_reset("mid_reset");
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, 0, 0);
            expect_all($sformatf("post_reset%0d", k), 0, 0, 0, 0, 0, 0, 1, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/branch_resolver.md
# branch_resolver

Backend companion to the bimodal predictor. Fetch records each predicted conditional branch in an in-order queue. Execute resolves branches oldest-first using the branch unit's flag; each resolution is compared against its recorded prediction. The block then produces a mispredict flush/redirect for fetch, and it paces PHT update pulses so the predictor never sees `update` asserted on two consecutive cycles.

## Interface
- `DEPTH_LOG2`, default 2: in-flight branch queue depth is 2^DEPTH_LOG2.
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `push_valid` in 1: fetch issues a predicted conditional branch.
- `push_pc` in 32: PC of that branch.
- `push_pred` in 1: predictor output for it (1 = taken).
- `push_ready` out 1: queue not full.
- `resolve_valid` in 1: execute resolves the oldest branch.
- `resolve_taken` in 1: branch unit flag.
- `resolve_target` in 32: computed taken target.
- `resolve_ready` out 1: queue non-empty and update buffer not full.
- `flush` out 1: one-cycle mispredict pulse.
- `redirect_pc` out 32: correct fetch PC; valid while `flush` = 1.
- `pc_update` out 32: PC to predictor update port.
- `update` out 1: predictor update strobe.
- `taken` out 1: actual outcome for the update.
- `occupancy` out DEPTH_LOG2+1: branch queue entry count.
- `mispredict_count` out 32: total mispredicts, wraps modulo 2^32.

## Operation
- **Branch queue:** circular FIFO of {pc, pred} with wrapping read and write pointers.
  - A push is accepted when `push_valid && push_ready`.
  - A push while full is dropped, and the state is unchanged.
- **Resolve handshake:** `resolve_valid && resolve_ready` pops the head and compares `resolve_taken` with `head.pred`.
  - `resolve_valid` while `resolve_ready` = 0 is ignored.
- **Mispredict:** when `resolve_taken != head.pred`:
  - The next cycle has `flush` = 1.
  - `redirect_pc` = `resolve_target` if actually taken, else `head.pc + 4` (32-bit wrap).
  - `mispredict_count` increments.
  - The whole queue is cleared at the same edge, because younger entries are wrong-path. A push accepted in the same cycle is also discarded.
- **Correct prediction:** the entry is popped with no flush.
- **Simultaneous push and resolve** without mispredict: both occur and `occupancy` is unchanged.
- **Update buffer:** 2-entry FIFO of {pc, taken}. Every resolution (correct or not) produces one entry.
- **Update pacing:** a registered update stage drives `update`, `pc_update` and `taken`. At each edge, if `update` is currently 0 and a candidate exists, the candidate is loaded and `update` <= 1; otherwise `update` <= 0.
  - The candidate is the buffer head, or, when the buffer is empty, the resolution in this cycle (bypass).
  - An unissued resolution enters the buffer.
  - Result: `update` never high on two consecutive cycles, and updates leave in resolve order.
- A flush does not discard buffered updates.
- **Reset:** the asynchronous assertion of `rstn` clears everything regardless of operation in progress. Reset values:
  - Pointers, `occupancy`, update buffer and `mispredict_count` = 0.
  - `flush` = 0, `update` = 0, `taken` = 0.
  - `redirect_pc` = 0, `pc_update` = 0.
  - `push_ready` = 1, `resolve_ready` = 0.

## Timing
- `push_ready`, `resolve_ready` and `occupancy` are combinational from registered state only; there is no input-to-output combinational path.
- **Flush latency:** a resolve handshake in cycle t gives `flush` and `redirect_pc` in cycle t+1. From cycle t+1, `occupancy` = 0.
- **Update latency:**
  - Minimum: a resolve in cycle t gives `update` in cycle t+1, provided `update` was 0 in cycle t and the buffer was empty.
  - Back-to-back resolves in t and t+1 give updates in t+1 and t+3.
- Update buffer full → `resolve_ready` = 0 until an entry drains. Worst-case drain rate is one update per 2 cycles.
- Counter wrap: 0xFFFFFFFF + 1 → 0.

## Test plan
- **Reset, then simple mispredict:**
  - Stimulus: push pc=0x100 with pred=1, then resolve taken=1; push pc=0x200 with pred=1, then resolve taken=0 with target=0x300.
  - Required: the first resolve gives no flush and update{0x100,1}. The second gives `flush` with `redirect_pc` = 0x204, update{0x200,0}, and `mispredict_count` = 1.
- **Taken mispredict clears queue:**
  - Stimulus: push 4 branches (pred=0), so `push_ready` = 0. Resolve the head with taken=1 and target=0x4000, while push_valid=1 in that same cycle.
  - Required: `redirect_pc` = 0x4000, `occupancy` = 0 the next cycle, and the concurrent push is discarded.
- **Update pacing:**
  - Stimulus: correctly resolve 3 branches on consecutive cycles t..t+2.
  - Required: `update` high in cycles t+1, t+3, t+5 only, with PCs in order. `resolve_ready` drops when the buffer holds 2 entries.
- **Simultaneous push and resolve at occupancy 2 without mispredict:**
  - Required: `occupancy` stays 2. Pointers wrap correctly after more than 8 pushes, with FIFO order preserved.
- **Resolve while queue empty, and push while full:**
  - Required: no handshake, no update, no state change.
- **Reset mid-operation:**
  - Stimulus: assert `rstn` = 0 asynchronously between edges while the queue holds 3 entries and an update is pending.
  - Required: all outputs reach their reset values immediately, and no `update` pulse follows release.
